// File: rtl/microwave_input_if.sv
// Front-panel bundle between the raw buttons and timer on one side and the
// microwave_input conditioning stage on the other.
interface microwave_input_if;
   logic       btn_start;
   logic       btn_stop;
   logic       btn_pause;
   logic       btn_min;
   logic       btn_sec;
   logic       btn_pwr;
   logic       done;
   logic       start;
   logic       stop;
   logic       pause;
   logic [6:0] min;
   logic [6:0] sec;
   logic [3:0] pwr;
   logic [5:0] d6;

   modport slave (
      input  btn_start, btn_stop, btn_pause, btn_min, btn_sec, btn_pwr, done,
      output start, stop, pause, min, sec, pwr, d6
   );

   modport master (
      output btn_start, btn_stop, btn_pause, btn_min, btn_sec, btn_pwr, done,
      input  start, stop, pause, min, sec, pwr, d6
   );
endinterface

// File: rtl/microwave_input.sv
// Microwave front panel: synchronises and debounces six buttons, issues
// single-cycle start/stop/pause commands and holds cook time and power level.
module microwave_input #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic              clock,
   input logic              reset,
   microwave_input_if.slave io
);
   localparam int NB      = 6;
   localparam int CW      = $clog2(DEBOUNCE_CYCLES);
   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_PAUSE = 2;
   localparam int B_MIN   = 3;
   localparam int B_SEC   = 4;
   localparam int B_PWR   = 5;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0] raw_s;
   logic [NB-1:0] sync1_q, sync2_q;
   logic [NB-1:0] deb_q, deb_d;
   logic [NB-1:0] press_q, press_d;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];
   logic          start_q, start_d;
   logic          stop_q, stop_d;
   logic          pause_q, pause_d;
   logic [6:0]    min_q, min_d;
   logic [6:0]    sec_q, sec_d;
   logic [3:0]    pwr_q, pwr_d;
   logic          zero_time_s;

   assign raw_s = {io.btn_pwr, io.btn_sec, io.btn_min,
                   io.btn_pause, io.btn_stop, io.btn_start};

   // Debounce: a sample matching the accepted state restarts the count.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = {CW{1'b0}};
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = {CW{1'b0}};
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1'b1);
         end
      end
      press_d = deb_d & ~deb_q;
   end

   assign zero_time_s = (min_q == 7'd0) && (sec_q == 7'd0);

   // Commands and time/power editing from the current press pulses.
   always_comb begin
      stop_d  = press_q[B_STOP];
      pause_d = press_q[B_PAUSE] & ~press_q[B_STOP];
      start_d = press_q[B_START] & ~press_q[B_STOP] & ~press_q[B_PAUSE]
                & ~(io.done & zero_time_s);
      min_d   = min_q;
      sec_d   = sec_q;
      pwr_d   = pwr_q;
      if (io.done) begin
         if (press_q[B_STOP]) begin
            min_d = 7'd0;
            sec_d = 7'd0;
         end else begin
            if (press_q[B_MIN]) begin
               min_d = (min_q == 7'd99) ? 7'd0 : min_q + 7'd1;
            end else begin
               min_d = min_q;
            end
            if (press_q[B_SEC]) begin
               sec_d = (sec_q == 7'd59) ? 7'd0 : sec_q + 7'd1;
            end else begin
               sec_d = sec_q;
            end
         end
      end else begin
         min_d = min_q;
         sec_d = sec_q;
      end
      if (press_q[B_PWR]) begin
         pwr_d = (pwr_q == 4'd9) ? 4'd1 : pwr_q + 4'd1;
      end else begin
         pwr_d = pwr_q;
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= {NB{1'b0}};
         sync2_q <= {NB{1'b0}};
         deb_q   <= {NB{1'b0}};
         press_q <= {NB{1'b0}};
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= {CW{1'b0}};
         end
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         pause_q <= 1'b0;
         min_q   <= 7'd0;
         sec_q   <= 7'd0;
         pwr_q   <= 4'd9;
      end else begin
         sync1_q <= raw_s;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         start_q <= start_d;
         stop_q  <= stop_d;
         pause_q <= pause_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         pwr_q   <= pwr_d;
      end
   end

   assign io.start = start_q;
   assign io.stop  = stop_q;
   assign io.pause = pause_q;
   assign io.min   = min_q;
   assign io.sec   = sec_q;
   assign io.pwr   = pwr_q;
   assign io.d6    = {1'b1, pwr_q, 1'b0};
endmodule

// File: doc/microwave_input.md
# microwave_input

Front-panel input stage of the microwave controller, feeding the countdown timer. Conditions the raw push-buttons (synchronise, debounce, rising-edge detect) and turns them into single-cycle `start`/`stop`/`pause` commands. Holds the operator-programmed cook time (`min`, `sec`) and power level, and produces the power-level digit for display slot 6. Its outputs connect directly to the timer's `start`, `stop`, `pause`, `min`, `sec` and `d6` inputs. The timer's `done` output is fed back here.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronised samples required to accept a button change (10 ms at 100 MHz). Legal range is 2 or more.

Ports:
- `clock` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset. Low immediately forces every register to its reset value.
- `btn_start` in 1: raw start button, active high, asynchronous to `clock`.
- `btn_stop` in 1: raw stop/clear button.
- `btn_pause` in 1: raw pause button.
- `btn_min` in 1: raw minute-increment button.
- `btn_sec` in 1: raw second-increment button.
- `btn_pwr` in 1: raw power-level button.
- `done` in 1: timer idle flag. When 1, the timer is idle and the time is editable.
- `start` out 1: one-cycle start command.
- `stop` out 1: one-cycle stop command.
- `pause` out 1: one-cycle pause/resume command.
- `min` out 7: programmed minutes, 0–99.
- `sec` out 7: programmed seconds, 0–59.
- `pwr` out 4: power level, 1–9.
- `d6` out 6: display word `{1'b1, pwr, 1'b0}`, meaning enabled, digit, decimal point off.

## Operation

**Per-button conditioning (six identical channels)**
- Two-flop synchroniser.
- Debounced state register, reset value 0.
- Stability counter, width `$clog2(DEBOUNCE_CYCLES)`:
  - When the synchronised sample equals the debounced state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` while the sample still differs, the debounced state takes the sample value and the counter clears.
- Press pulse `p_x`: registered, high for exactly one cycle after a 0→1 transition of the debounced state. A release produces no pulse.

**Command outputs** (registered, driven from the same-cycle `p_x`)
- Priority stop > pause > start. At most one command output is high in any cycle.
- `stop` = `p_stop`.
- `pause` = `p_pause & ~p_stop`.
- `start` = `p_start & ~p_stop & ~p_pause & ~(done & min==0 & sec==0)`. Starting with zero time while idle is suppressed.

**Time and power registers** (update on the clock edge after `p_x`; only when `done`=1, otherwise the press is ignored)
- `p_min`: min ← (min==99) ? 0 : min+1.
- `p_sec`: sec ← (sec==59) ? 0 : sec+1. No carry into min.
- `p_pwr`: pwr ← (pwr==9) ? 1 : pwr+1. Allowed in any `done` state.
- `p_stop` with `done`=1: min ← 0 and sec ← 0. The stop command is still issued.
- Simultaneous `p_min` and `p_sec`: both apply.
- Simultaneous `p_stop` and `p_min`/`p_sec`: the clear wins.
- `min` and `sec` are never modified while `done`=0. The timer samples them only while idle.

## Timing

- Reset values:
  - `start`/`stop`/`pause` = 0.
  - `min` = 0, `sec` = 0, `pwr` = 9.
  - `d6` = 6'b110010.
  - All debounced states, counters and synchroniser flops = 0.
- Latency from a clean input edge to the command pulse: 2 (synchroniser) + `DEBOUNCE_CYCLES` + 1 cycles.
- `min`/`sec`/`pwr` change one cycle after the internal press pulse.
- `d6` is combinational from `pwr`.
- Bounce: any sample matching the current debounced state restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- A held button produces exactly one pulse. There is no auto-repeat.
- `done` is sampled in the same cycle as the press pulse. A `done` change in that cycle uses the pre-edge value.
- Reset asserted mid-debounce or mid-pulse: outputs drop immediately. After release, no pulse is generated for a button that was already held; the debounced state must first rise from 0 under normal rules.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset` low with all buttons at 1, then release. Required: min=0, sec=0, pwr=9, d6=6'b110010, no command until the buttons are debounced; then one pulse per held button, with `start` suppressed because the time is zero.
- **Bounce:** toggle `btn_start` high/low every 2 cycles for 20 cycles, then hold it high with `done`=0. Required: exactly one `start` pulse, 7 cycles after the final rise.
- **Edit and wrap:** with `done`=1, press `btn_sec` 61 times, then assert `btn_min` and `btn_sec` together. Required: sec goes 1…59, 0, 1, then sec=2 and min=1 after the simultaneous press.
- **Edit lockout and clear:** program 3:15, set `done`=0, press `btn_min`. Required: min stays 3. Then set `done`=1 and press `btn_stop`. Required: one `stop` pulse, and min=0, sec=0 on the next cycle.
- **Priority:** debounce `btn_stop`, `btn_pause` and `btn_start` together with `done`=0. Required: only `stop` pulses. With only `pause` and `start` pressed: only `pause` pulses.
- **Power:** press `btn_pwr` 9 times starting from reset. Required: pwr goes 1, 2, …, 9 and `d6` tracks `{1, pwr, 0}`.
